vec_add_master: RTL and testbench
=================================

VEC_ADD_MASTER -- requirements
Module: vec_add_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, on ports clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-005 SrcAddr1  input  16  first operand base word address.
REQ-006 SrcAddr2  input  16  second operand base word address.
REQ-007 DstAddr  input  16  result base word address.
REQ-008 Length  input  16  number of 128-bit words to process; 0 is legal.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 ReadAddress1, ReadAddress2  output  16 each  memory read addresses.
REQ-012 ReadBus1, ReadBus2  input  128 each  memory read data; combinational from addresses, settled before the next rising edge.
REQ-013 WE  output  1  memory write enable.
REQ-014 WriteAddress  output  16  memory write address.
REQ-015 WriteBus  output  128  memory write data.

Function
REQ-016 All outputs SHALL be registered; memory-side outputs SHALL change only on rising edges.
REQ-017 The FSM SHALL have states IDLE, READ, CAP, WRITE, FIN.
REQ-018 IDLE with start=1 and Length!=0: latch the three bases and Length, go to READ. With Length=0: go to FIN (no memory traffic).
REQ-019 READ: drive ReadAddress1/2 = current src pointers, WE=0; next state CAP.
REQ-020 CAP: register Sum = lane-wise add of ReadBus1 and ReadBus2 (8 unsigned 16-bit lanes, bits [16k+15:16k]); next state WRITE.
REQ-021 WRITE: WE=1 for exactly one cycle, WriteAddress = dst pointer, WriteBus = Sum. Increment all three pointers by 1 and decrement the remaining count; go to READ if the count is nonzero after the decrement, else go to FIN.
REQ-022 FIN: done=1 for one cycle, busy=0 in that same cycle; next state IDLE.
REQ-023 Throughput SHALL be exactly 3 cycles per word; total start-to-done latency SHALL be 3*Length+1 cycles (Length=0: done in the cycle after start).
REQ-024 Pointers SHALL wrap modulo 2^16 (0xFFFF+1 -> 0x0000).
REQ-025 Lane carries SHALL NOT propagate between lanes.
REQ-026 start while not in IDLE SHALL be ignored; command inputs are don't-care outside IDLE.
REQ-027 Overlapping source/destination ranges SHALL be legal; word i is read before word i is written, and word i+1 is read after word i is written.
REQ-028 WE SHALL be 0 in every state except WRITE.

Reset
REQ-029 On reset, in any state: the FSM goes to IDLE, and busy=0, done=0, WE=0, and all address/data outputs are 0.
REQ-030 A reset during WRITE SHALL leave WE low from the next edge; a partially written range is not restored.
REQ-031 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 The macro VEC_ADD_SAT_EN SHALL select the lane arithmetic. When defined, each lane saturates at 0xFFFF. When undefined, each lane wraps modulo 2^16.

Verification
REQ-033 Length=1, mem[0x10]=lanes 0x0001, mem[0x20]=lanes 0x0002, Dst=0x30 -> WE high for one cycle with WriteAddress=0x30 and all lanes 0x0003; done asserted 4 cycles after start.
REQ-034 Length=0 with start -> done pulse on the next cycle; WE never asserted; busy never asserted.
REQ-035 Lane values 0xFFFF+0x0002 -> without VEC_ADD_SAT_EN, lane=0x0001 and the neighbour lane is unchanged; with VEC_ADD_SAT_EN, lane=0xFFFF.
REQ-036 Src1=0xFFFE, Src2=0x0000, Dst=0xFFFF, Length=3 -> write addresses in order 0xFFFF, 0x0000, 0x0001; read addresses wrap 0xFFFF to 0x0000; done at cycle 10.
REQ-037 Second start pulsed mid-transfer, then reset asserted during a WRITE cycle -> second start ignored; on the next edge WE=0, busy=0, FSM in IDLE; a fresh start runs normally.
REQ-038 In-place add, Dst=Src1=0x40, Length=4 -> each mem[0x40+i] equals the old value plus mem[Src2+i]; exactly 4 WE pulses.

Source files
------------

// File: rtl/vec_add_master.sv
// Vector add master: reads two 128-bit operand streams, adds 8 x 16-bit lanes, writes results.
// Define VEC_ADD_SAT_EN for saturating lanes; the default build wraps each lane modulo 2^16.
module vec_add_master (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  SrcAddr1,
  input  logic [15:0]  SrcAddr2,
  input  logic [15:0]  DstAddr,
  input  logic [15:0]  Length,
  output logic         busy,
  output logic         done,
  output logic [15:0]  ReadAddress1,
  output logic [15:0]  ReadAddress2,
  input  logic [127:0] ReadBus1,
  input  logic [127:0] ReadBus2,
  output logic         WE,
  output logic [15:0]  WriteAddress,
  output logic [127:0] WriteBus
);

  typedef enum logic [2:0] {IDLE, READ, CAP, WRITE, FIN} state_t;

  state_t         state_q, state_d;
  logic [15:0]    src1_q, src1_d, src2_q, src2_d, dst_q, dst_d, count_q, count_d;
  logic [15:0]    ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic [127:0]   wb_q, wb_d;
  logic           we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [127:0]   lane_sum;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
`ifdef VEC_ADD_SAT_EN
      logic [16:0] wide;
      assign wide = {1'b0, ReadBus1[16*gi +: 16]} + {1'b0, ReadBus2[16*gi +: 16]};
      assign lane_sum[16*gi +: 16] = wide[16] ? 16'hFFFF : wide[15:0];
`else
      assign lane_sum[16*gi +: 16] = ReadBus1[16*gi +: 16] + ReadBus2[16*gi +: 16];
`endif
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dst_d   = dst_q;
    count_d = count_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (Length != 16'd0) begin
            src1_d  = SrcAddr1;
            src2_d  = SrcAddr2;
            dst_d   = DstAddr;
            count_d = Length;
            state_d = READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ:  state_d = CAP;
      CAP: begin
        wa_d    = dst_q;
        wb_d    = lane_sum;
        state_d = WRITE;
      end
      WRITE: begin
        src1_d  = src1_q + 16'd1;
        src2_d  = src2_q + 16'd1;
        dst_d   = dst_q + 16'd1;
        count_d = count_q - 16'd1;
        state_d = (count_q != 16'd1) ? READ : FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered yet aligned with it.
    if (state_d == READ) begin
      ra1_d = src1_d;
      ra2_d = src2_d;
    end
    we_d   = (state_d == WRITE);
    busy_d = (state_d == READ) || (state_d == CAP) || (state_d == WRITE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src1_q  <= 16'd0;
      src2_q  <= 16'd0;
      dst_q   <= 16'd0;
      count_q <= 16'd0;
      ra1_q   <= 16'd0;
      ra2_q   <= 16'd0;
      wa_q    <= 16'd0;
      wb_q    <= 128'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ReadAddress1 = ra1_q;
  assign ReadAddress2 = ra2_q;
  assign WE           = we_q;
  assign WriteAddress = wa_q;
  assign WriteBus     = wb_q;

endmodule

// File: tb/tb_vec_add_master.sv
// Directed bench for vec_add_master with a 64K x 128-bit memory model and a negedge monitor.
module tb_vec_add_master;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  SrcAddr1 = '0, SrcAddr2 = '0, DstAddr = '0, Length = '0;
  logic         busy, done, WE;
  logic [15:0]  ReadAddress1, ReadAddress2, WriteAddress;
  logic [127:0] ReadBus1, ReadBus2, WriteBus;

  logic [127:0] mem [0:65535];
  logic         pl_en = 1'b0;
  logic [15:0]  pl_addr = '0;
  logic [127:0] pl_data = '0;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0, busy_cnt = 0, done_cnt = 0;
  logic [15:0] wa_log[$];
  logic [15:0] ra_log[$];

  vec_add_master dut (
    .clock(clock), .reset(reset), .start(start),
    .SrcAddr1(SrcAddr1), .SrcAddr2(SrcAddr2), .DstAddr(DstAddr), .Length(Length),
    .busy(busy), .done(done),
    .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
    .ReadBus1(ReadBus1), .ReadBus2(ReadBus2),
    .WE(WE), .WriteAddress(WriteAddress), .WriteBus(WriteBus)
  );

  always #5 clock = ~clock;

  assign ReadBus1 = mem[ReadAddress1];
  assign ReadBus2 = mem[ReadAddress2];

  always @(posedge clock) begin
    if (WE) mem[WriteAddress] = WriteBus;
    else if (pl_en) mem[pl_addr] = pl_data;
  end

  always @(negedge clock) begin
    if (WE) begin
      we_cnt++;
      wa_log.push_back(WriteAddress);
      ra_log.push_back(ReadAddress1);
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [127:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic run(input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] d,
                     input logic [15:0] len, output int lat);
    SrcAddr1 = s1;
    SrcAddr2 = s2;
    DstAddr  = d;
    Length   = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    chk("done_seen", done, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    tick();
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int lat, wb, bb, lb, n;
    logic [127:0] a_v, b_v, exp_v;

    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", WE, 1'b0);
    chk("rst_ra1", ReadAddress1, 16'h0);
    chk("rst_ra2", ReadAddress2, 16'h0);
    chk("rst_wa", WriteAddress, 16'h0);
    chk("rst_wb", WriteBus, 128'h0);
    reset = 1'b0;
    tick();

    // Single word
    preload(16'h0010, {8{16'h0001}});
    preload(16'h0020, {8{16'h0002}});
    wb = we_cnt; bb = busy_cnt; lb = wa_log.size();
    run(16'h0010, 16'h0020, 16'h0030, 16'd1, lat);
    $display("txn len1: latency=%0d writes=%0d", lat, we_cnt - wb);
    chk("len1_latency", lat, 4);
    chk("len1_we_pulses", we_cnt - wb, 1);
    chk("len1_busy_cycles", busy_cnt - bb, 3);
    chk("len1_waddr", wa_log[lb], 16'h0030);
    chk("len1_data", mem[16'h0030], {8{16'h0003}});

    // Zero length
    wb = we_cnt; bb = busy_cnt;
    run(16'h0010, 16'h0020, 16'h0031, 16'd0, lat);
    $display("txn len0: latency=%0d writes=%0d", lat, we_cnt - wb);
    chk("len0_latency", lat, 1);
    chk("len0_we_pulses", we_cnt - wb, 0);
    chk("len0_busy_cycles", busy_cnt - bb, 0);

    // Lane isolation and overflow behaviour
    a_v = {16'h7FFF, 16'h0000, 16'hFFFF, 16'h00FF, 16'h0101, 16'h8000, 16'h1234, 16'hFFFF};
    b_v = {16'h0001, 16'h0000, 16'h0000, 16'hFF01, 16'h0202, 16'h8000, 16'h0001, 16'h0002};
`ifdef VEC_ADD_SAT_EN
    exp_v = {16'h8000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0303, 16'hFFFF, 16'h1235, 16'hFFFF};
`else
    exp_v = {16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0303, 16'h0000, 16'h1235, 16'h0001};
`endif
    preload(16'h0050, a_v);
    preload(16'h0058, b_v);
    run(16'h0050, 16'h0058, 16'h005C, 16'd1, lat);
    $display("txn lanes: result=%h", mem[16'h005C]);
    chk("lanes_data", mem[16'h005C], exp_v);

    // Address wrap with overlapping destination
    preload(16'hFFFE, {8{16'd1}});
    preload(16'hFFFF, {8{16'd10}});
    preload(16'h0000, {8{16'd100}});
    preload(16'h0001, {8{16'd1000}});
    preload(16'h0002, {8{16'd7}});
    wb = we_cnt; lb = wa_log.size();
    run(16'hFFFE, 16'h0000, 16'hFFFF, 16'd3, lat);
    $display("txn wrap: latency=%0d writes=%0d", lat, we_cnt - wb);
    chk("wrap_latency", lat, 10);
    chk("wrap_we_pulses", we_cnt - wb, 3);
    chk("wrap_wa0", wa_log[lb], 16'hFFFF);
    chk("wrap_wa1", wa_log[lb+1], 16'h0000);
    chk("wrap_wa2", wa_log[lb+2], 16'h0001);
    chk("wrap_ra0", ra_log[lb], 16'hFFFE);
    chk("wrap_ra1", ra_log[lb+1], 16'hFFFF);
    chk("wrap_ra2", ra_log[lb+2], 16'h0000);
    chk("wrap_mem_ffff", mem[16'hFFFF], {8{16'd101}});
    chk("wrap_mem_0000", mem[16'h0000], {8{16'd1101}});
    chk("wrap_mem_0001", mem[16'h0001], {8{16'd1108}});

    // Ignored restart, then reset in the middle of a WRITE
    preload(16'h0060, {8{16'h0005}});
    preload(16'h0070, {8{16'h0006}});
    wb = we_cnt; bb = done_cnt;
    SrcAddr1 = 16'h0060; SrcAddr2 = 16'h0070; DstAddr = 16'h0080; Length = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    SrcAddr1 = 16'h0099; DstAddr = 16'h00AA; Length = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!WE && n < 20) begin
      tick();
      n++;
    end
    chk("rstw_we_seen", WE, 1'b1);
    chk("rstw_waddr", WriteAddress, 16'h0080);
    chk("rstw_no_done", done_cnt - bb, 0);
    reset = 1'b1;
    tick();
    $display("txn reset-in-write: we=%b busy=%b done=%b", WE, busy, done);
    chk("rstw_we_low", WE, 1'b0);
    chk("rstw_busy_low", busy, 1'b0);
    chk("rstw_done_low", done, 1'b0);
    chk("rstw_wa_zero", WriteAddress, 16'h0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("rstw_we_pulses", we_cnt - wb, 1);
    chk("rstw_partial", mem[16'h0080], {8{16'h000B}});
    run(16'h0060, 16'h0070, 16'h0084, 16'd1, lat);
    $display("txn after-reset: latency=%0d", lat);
    chk("rstw_fresh_latency", lat, 4);
    chk("rstw_fresh_data", mem[16'h0084], {8{16'h000B}});

    // In-place accumulate
    preload(16'h0040, {8{16'h0010}});
    preload(16'h0041, {8{16'h0020}});
    preload(16'h0042, {8{16'h0030}});
    preload(16'h0043, {8{16'hFFF0}});
    preload(16'h0090, {8{16'h0001}});
    preload(16'h0091, {8{16'h0002}});
    preload(16'h0092, {8{16'h0003}});
    preload(16'h0093, {8{16'h0004}});
    wb = we_cnt;
    run(16'h0040, 16'h0090, 16'h0040, 16'd4, lat);
    $display("txn inplace: latency=%0d writes=%0d", lat, we_cnt - wb);
    chk("inplace_latency", lat, 13);
    chk("inplace_we_pulses", we_cnt - wb, 4);
    chk("inplace_m0", mem[16'h0040], {8{16'h0011}});
    chk("inplace_m1", mem[16'h0041], {8{16'h0022}});
    chk("inplace_m2", mem[16'h0042], {8{16'h0033}});
    chk("inplace_m3", mem[16'h0043], {8{16'hFFF4}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
